// File: rtl/ce_phase_gen.sv
// Capture-strobe generator for slow-CE crossings: synchronises the aclk toggle, locks a
// modulo-RATIO phase counter to it and fires ben_o at phase OFFSET while locked.
module ce_phase_gen #(
  parameter int RATIO  = 4,
  parameter int OFFSET = 2,
  parameter int SYNC   = 2,
  parameter int LOCKS  = 4,
  localparam int PW    = $clog2(RATIO),
  localparam int GW    = $clog2(LOCKS + 1)
) (
  input  logic          bclk,
  input  logic          arst,
  input  logic          atog_i,
  output logic          ben_o,
  output logic          locked_o,
  output logic [PW-1:0] phase_o,
  output logic          slip_o,
  output logic [7:0]    slips_o
);

  typedef enum logic [1:0] {SEEK, VERIFY, LOCKED} state_t;

  localparam logic [PW-1:0] LAST  = PW'(RATIO - 1);
  localparam logic [PW-1:0] OFF   = PW'(OFFSET);
  localparam logic [GW-1:0] GMAX  = GW'(LOCKS);

  logic [SYNC-1:0] sync_q;
  logic            prev_q;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   good_q, good_d;
  state_t          state_q, state_d;
  logic            ben_q, ben_d;
  logic            locked_q, locked_d;
  logic            slip_q, slip_d;
  logic [7:0]      slips_q, slips_d;
  logic            atogEdge;
  logic            reload;

  always_ff @(posedge bclk) begin
    if (!arst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], atog_i};
      prev_q <= sync_q[SYNC-1];
    end
  end

  assign atogEdge = sync_q[SYNC-1] ^ prev_q;

  // The phase counter sits at 0 in the edge cycle, so a reload lands it on 1 next.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    reload  = 1'b0;
    slip_d  = 1'b0;
    case (state_q)
      SEEK: begin
        if (atogEdge) begin
          reload  = 1'b1;
          good_d  = '0;
          state_d = VERIFY;
        end
      end
      VERIFY: begin
        if (atogEdge && cnt_q == '0) begin
          if (good_q + GW'(1) >= GMAX) begin
            good_d  = GMAX;
            state_d = LOCKED;
          end else begin
            good_d = good_q + GW'(1);
          end
        end else if (atogEdge) begin
          reload = 1'b1;
          good_d = '0;
        end else if (cnt_q == '0) begin
          state_d = SEEK;
        end
      end
      LOCKED: begin
        if (atogEdge && cnt_q != '0) begin
          slip_d  = 1'b1;
          reload  = 1'b1;
          good_d  = '0;
          state_d = VERIFY;
        end else if (!atogEdge && cnt_q == '0) begin
          slip_d  = 1'b1;
          good_d  = '0;
          state_d = SEEK;
        end
      end
      default: state_d = SEEK;
    endcase

    if (reload)
      cnt_d = PW'(1);
    else if (cnt_q == LAST)
      cnt_d = '0;
    else
      cnt_d = cnt_q + PW'(1);

    slips_d  = (slip_d && slips_q != 8'hFF) ? slips_q + 8'd1 : slips_q;
    locked_d = (state_d == LOCKED);
    // Decided from next-state values so ben_o lines up with locked_o and phase_o.
    ben_d    = locked_d && (cnt_d == OFF);
  end

  always_ff @(posedge bclk) begin
    if (!arst) begin
      state_q  <= SEEK;
      cnt_q    <= '0;
      good_q   <= '0;
      ben_q    <= 1'b0;
      locked_q <= 1'b0;
      slip_q   <= 1'b0;
      slips_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      ben_q    <= ben_d;
      locked_q <= locked_d;
      slip_q   <= slip_d;
      slips_q  <= slips_d;
    end
  end

  assign ben_o    = ben_q;
  assign locked_o = locked_q;
  assign phase_o  = cnt_q;
  assign slip_o   = slip_q;
  assign slips_o  = slips_q;

endmodule

// File: tb/tb_ce_phase_gen.sv
// Testbench for ce_phase_gen: reset table, directed lock/slip/reset scenarios and
// randomized toggle timing, all compared each cycle against a phase-anchor reference model.
module tb_ce_phase_gen;

  localparam int RATIO  = 4;
  localparam int OFFSET = 2;
  localparam int SYNC   = 2;
  localparam int LOCKS  = 4;
  localparam int PW     = $clog2(RATIO);

  logic          bclk = 1'b0;
  logic          arst = 1'b0;
  logic          atog = 1'b0;
  logic          ben;
  logic          locked;
  logic [PW-1:0] phase;
  logic          slip;
  logic [7:0]    slips;

  int testsRun = 0;
  int failures = 0;

  ce_phase_gen #(.RATIO(RATIO), .OFFSET(OFFSET), .SYNC(SYNC), .LOCKS(LOCKS)) dut (
    .bclk     (bclk),
    .arst     (arst),
    .atog_i   (atog),
    .ben_o    (ben),
    .locked_o (locked),
    .phase_o  (phase),
    .slip_o   (slip),
    .slips_o  (slips)
  );

  always #5 bclk = ~bclk;

  // Reference model: phase is the distance from an anchor cycle (where phase 0 sits),
  // and the input is seen through a plain history of sampled toggle values.
  int mN      = 0;
  int mAnchor = 0;
  int mMode   = 0;
  int mGood   = 0;
  int mSlips  = 0;
  int mSlip   = 0;
  int mBen    = 0;
  int mLocked = 0;
  int mPhase  = 0;
  int mSamp [SYNC+1];

  int   benCount   = 0;
  int   benBad     = 0;
  int   slipCount  = 0;
  int   lockedSeen = 0;
  logic togState   = 1'b0;

  typedef struct {
    logic rstN;
    logic tog;
    int   expBen;
    int   expLocked;
    int   expPhase;
    int   expSlips;
  } vec_t;

  vec_t vecs [11];

  function automatic void check(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, mN);
    end
  endfunction

  function automatic void modelStep(input logic rstN, input logic tog);
    int e, p, rel;
    mN++;
    mSlip = 0;
    if (!rstN) begin
      for (int i = 0; i <= SYNC; i++) mSamp[i] = 0;
      mAnchor = mN;
      mMode   = 0;
      mGood   = 0;
      mSlips  = 0;
    end else begin
      e   = mSamp[SYNC-1] ^ mSamp[SYNC];
      p   = (mN - 1 - mAnchor) % RATIO;
      rel = 0;
      if (mMode == 0) begin
        if (e != 0) begin rel = 1; mGood = 0; mMode = 1; end
      end else if (mMode == 1) begin
        if (e != 0 && p == 0) begin
          mGood = (mGood + 1 > LOCKS) ? LOCKS : mGood + 1;
          if (mGood >= LOCKS) mMode = 2;
        end else if (e != 0) begin
          rel = 1; mGood = 0;
        end else if (p == 0) begin
          mMode = 0;
        end
      end else begin
        if ((e != 0 && p != 0) || (e == 0 && p == 0)) begin
          mSlip  = 1;
          mSlips = (mSlips < 255) ? mSlips + 1 : 255;
          mGood  = 0;
          if (e != 0) begin rel = 1; mMode = 1; end
          else mMode = 0;
        end
      end
      if (rel != 0) mAnchor = mN - 1;
      for (int i = SYNC; i > 0; i--) mSamp[i] = mSamp[i-1];
      mSamp[0] = int'(tog);
    end
    mPhase  = (mN - mAnchor) % RATIO;
    mLocked = (mMode == 2) ? 1 : 0;
    mBen    = (mLocked != 0 && mPhase == OFFSET) ? 1 : 0;
  endfunction

  task automatic applyStimulus(input logic rstN, input logic tog);
    @(negedge bclk);
    arst = rstN;
    atog = tog;
    @(posedge bclk);
    modelStep(rstN, tog);
    #1;
    check("ben", int'(ben), mBen);
    check("locked", int'(locked), mLocked);
    check("phase", int'(phase), mPhase);
    check("slip", int'(slip), mSlip);
    check("slips", int'(slips), mSlips);
    benCount   += int'(ben);
    slipCount  += int'(slip);
    lockedSeen |= int'(locked);
    if (ben && int'(phase) != OFFSET) benBad++;
  endtask

  task automatic togglePeriod(input int period, input int count);
    for (int k = 0; k < count; k++) begin
      togState = ~togState;
      for (int c = 0; c < period; c++) applyStimulus(1'b1, togState);
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    check(name, act, exp);
  endtask

  initial begin
    for (int i = 0; i <= SYNC; i++) mSamp[i] = 0;
    for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 1'b0, 0, 0, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 0, 0, 1, 0};
    vecs[6]  = '{1'b1, 1'b0, 0, 0, 2, 0};
    vecs[7]  = '{1'b1, 1'b0, 0, 0, 3, 0};
    vecs[8]  = '{1'b1, 1'b0, 0, 0, 0, 0};
    vecs[9]  = '{1'b1, 1'b0, 0, 0, 1, 0};
    vecs[10] = '{1'b1, 1'b0, 0, 0, 2, 0};

    // Reset hold followed by free-running phase with no toggles.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].tog);
      checkOutput("tbl_ben", int'(ben), vecs[i].expBen);
      checkOutput("tbl_locked", int'(locked), vecs[i].expLocked);
      checkOutput("tbl_phase", int'(phase), vecs[i].expPhase);
      checkOutput("tbl_slips", int'(slips), vecs[i].expSlips);
    end

    // Lock to a period-4 toggle: five detected edges needed.
    togglePeriod(4, 4);
    checkOutput("not_locked_after_4_edges", int'(locked), 0);
    togglePeriod(4, 1);
    checkOutput("locked_after_5_edges", int'(locked), 1);
    benCount = 0;
    benBad   = 0;
    togglePeriod(4, 4);
    checkOutput("ben_pulses_16_cycles", benCount, 4);
    checkOutput("ben_off_phase", benBad, 0);

    // One toggle late by a single cycle: one slip, then relock after 4 good edges.
    slipCount = 0;
    applyStimulus(1'b1, togState);
    togglePeriod(4, 1);
    checkOutput("late_slip_count", slipCount, 1);
    checkOutput("late_slips", int'(slips), 1);
    checkOutput("late_unlocked", int'(locked), 0);
    togglePeriod(4, 3);
    checkOutput("late_not_yet_relocked", int'(locked), 0);
    togglePeriod(4, 1);
    checkOutput("late_relocked", int'(locked), 1);

    // Toggling stops: slip at the next phase 0, then silence.
    slipCount = 0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, togState);
    benCount = 0;
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, togState);
    checkOutput("stop_slip_count", slipCount, 1);
    checkOutput("stop_slips", int'(slips), 2);
    checkOutput("stop_ben_quiet", benCount, 0);
    checkOutput("stop_unlocked", int'(locked), 0);

    // Wrong ratio never locks.
    applyStimulus(1'b0, togState);
    lockedSeen = 0;
    benCount   = 0;
    togglePeriod(5, 12);
    checkOutput("ratio5_never_locked", lockedSeen, 0);
    checkOutput("ratio5_no_ben", benCount, 0);

    // One-cycle reset mid-period while locked.
    togglePeriod(4, 6);
    checkOutput("prereset_locked", int'(locked), 1);
    applyStimulus(1'b1, togState);
    applyStimulus(1'b0, togState);
    checkOutput("rst_ben", int'(ben), 0);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_phase", int'(phase), 0);
    checkOutput("rst_slip", int'(slip), 0);
    checkOutput("rst_slips", int'(slips), 0);
    togglePeriod(4, 7);
    checkOutput("relock_after_reset", int'(locked), 1);

    // Slip counter saturation at 255.
    for (int i = 0; i < 258; i++) begin
      applyStimulus(1'b1, togState);
      togglePeriod(4, 5);
    end
    checkOutput("slips_saturated", int'(slips), 255);
    checkOutput("saturated_relocked", int'(locked), 1);

    // Randomised toggle timing with occasional resets.
    begin
      int remain;
      remain = 4;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 299) == 0) begin
          applyStimulus(1'b0, togState);
        end else begin
          if (remain == 0) begin
            togState = ~togState;
            case ($urandom_range(0, 9))
              0:       remain = 3;
              1:       remain = 5;
              default: remain = 4;
            endcase
          end
          applyStimulus(1'b1, togState);
          remain--;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
